// File: rtl/periph_map_pkg.sv
// Peripheral window map, FSM state encoding and shared types for the
// CPU-to-peripheral bus controller.
package periph_map_pkg;

    localparam logic [31:0] DEFAULT_PERIPH_BASE    = 32'h1001_0020;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    // Register addresses, low byte of the absolute address
    localparam logic [7:0] OFF_LEDS     = 8'h24;
    localparam logic [7:0] OFF_SWITCHES = 8'h28;
    localparam logic [7:0] OFF_UART_TX  = 8'h2C;
    localparam logic [7:0] OFF_UART_RX  = 8'h30;
    localparam logic [7:0] OFF_STATUS   = 8'h34;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_TX_WAIT = 2'd2;

    // One-hot register select produced by the address decoder
    typedef struct packed {
        logic leds;
        logic switches;
        logic uart_tx;
        logic uart_rx;
        logic status;
    } periph_sel_t;

    function automatic logic [31:0] status_word(input logic rx_valid, input logic busy);
        return {30'b0, rx_valid, busy};
    endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// CPU data-port bus as seen by the peripheral controller.
// master = CPU side, slave = periph_bus_ctrl.
interface periph_bus_ctrl_if;

    logic        req;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        periph_hit;

    modport master (
        output req, HADDR, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP, periph_hit
    );

    modport slave (
        input  req, HADDR, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP, periph_hit
    );

endinterface

// File: rtl/periph_bus_ctrl_addr_decode.sv
// Combinational decoder for the 32-byte peripheral window: one-hot
// register select, window hit, and error (unmapped offset, misaligned
// address or wrong access direction).
module periph_addr_decode
    import periph_map_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE
) (
    input  logic [31:0] haddr,
    input  logic        hwrite,
    output periph_sel_t sel,
    output logic        hit,
    output logic        err
);

    // Window match on the upper address bits, then register/direction decode
    always_comb begin
        sel = '0;
        err = 1'b0;
        hit = (haddr[31:5] == PERIPH_BASE[31:5]);
        if (hit) begin
            if (haddr[1:0] != 2'b00) begin
                err = 1'b1;
            end else begin
                case (haddr[4:0])
                    OFF_LEDS[4:0]:     sel.leds = 1'b1;
                    OFF_SWITCHES[4:0]: if (!hwrite) sel.switches = 1'b1; else err = 1'b1;
                    OFF_UART_TX[4:0]:  if (hwrite)  sel.uart_tx  = 1'b1; else err = 1'b1;
                    OFF_UART_RX[4:0]:  if (!hwrite) sel.uart_rx  = 1'b1; else err = 1'b1;
                    OFF_STATUS[4:0]:   if (!hwrite) sel.status   = 1'b1; else err = 1'b1;
                    default:           err = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Sequencing controller between the CPU data port and the GPIO/UART
// peripherals. Generates one-cycle peripheral strobes, inserts wait states
// for registered reads and UART TX back-pressure, returns read data/errors.
// Optional feature macro: BUS_TIMEOUT_EN (bounded TX_WAIT with error reply).
module periph_bus_ctrl
    import periph_map_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE    = DEFAULT_PERIPH_BASE,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    periph_bus_ctrl_if.slave    bus,
    output logic                enable_LEDS,
    output logic                enable_SWITCHES,
    input  logic [31:0]         gpio_rdata,
    output logic                enable_uart_tx,
    output logic                enable_uart_rx,
    input  logic [31:0]         uart_rdata,
    input  logic                uart_busy,
    input  logic                uart_rx_valid
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  led_shadow_q, led_shadow_d;
    periph_sel_t sel;
    logic        hit;
    logic        dec_err;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        tmo_expired;

    periph_addr_decode #(
        .PERIPH_BASE (PERIPH_BASE)
    ) u_decode (
        .haddr  (bus.HADDR),
        .hwrite (bus.HWRITE),
        .sel    (sel),
        .hit    (hit),
        .err    (dec_err)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter holds the number of TX_WAIT cycles already spent; the reply
    // comes in the TX_WAIT cycle that brings the stall to TIMEOUT_CYCLES.
    assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count while remaining in TX_WAIT, clear on any other transition
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_TX_WAIT && state_d == ST_TX_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES < 2);
    assign tmo_expired    = 1'b0;
`endif

    logic unused_hwdata;
    assign unused_hwdata = ^bus.HWDATA[31:8];

    // Access sequencing: strobes, ready/error, read mux and next state.
    // While reset is asserted all outputs are held at their reset values so
    // an access held across reset cannot fire a strobe.
    always_comb begin
        state_d         = state_q;
        led_shadow_d    = led_shadow_q;
        hready          = 1'b1;
        hresp           = 1'b0;
        hrdata          = '0;
        enable_LEDS     = 1'b0;
        enable_SWITCHES = 1'b0;
        enable_uart_tx  = 1'b0;
        enable_uart_rx  = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req && hit) begin
                        if (dec_err) begin
                            hresp = 1'b1;
                        end else if (sel.leds) begin
                            if (bus.HWRITE) begin
                                enable_LEDS  = 1'b1;
                                led_shadow_d = bus.HWDATA[7:0];
                            end else begin
                                hrdata = {24'b0, led_shadow_q};
                            end
                        end else if (sel.status) begin
                            hrdata = status_word(uart_rx_valid, uart_busy);
                        end else if (sel.switches) begin
                            enable_SWITCHES = 1'b1;
                            hready          = 1'b0;
                            state_d         = ST_RD_WAIT;
                        end else if (sel.uart_rx) begin
                            enable_uart_rx = 1'b1;
                            hready         = 1'b0;
                            state_d        = ST_RD_WAIT;
                        end else if (sel.uart_tx) begin
                            if (!uart_busy) begin
                                enable_uart_tx = 1'b1;
                            end else begin
                                hready  = 1'b0;
                                state_d = ST_TX_WAIT;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    state_d = ST_IDLE;
                    if (bus.req && hit) begin
                        hrdata = sel.uart_rx ? uart_rdata : gpio_rdata;
                    end
                end
                ST_TX_WAIT: begin
                    if (!bus.req) begin
                        state_d = ST_IDLE;
                    end else if (!uart_busy) begin
                        enable_uart_tx = 1'b1;
                        state_d        = ST_IDLE;
                    end else if (tmo_expired) begin
                        hresp   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hready = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and LED shadow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            led_shadow_q <= '0;
        end else begin
            state_q      <= state_d;
            led_shadow_q <= led_shadow_d;
        end
    end

    assign bus.HREADY     = hready;
    assign bus.HRESP      = hresp;
    assign bus.HRDATA     = hrdata;
    assign bus.periph_hit = reset && bus.req && hit;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl: directed scenarios plus a
// randomized run against a transaction-level model of the window.
module tb_periph_bus_ctrl;

    localparam int unsigned TMO  = 8;
    localparam logic [31:0] BASE = 32'h1001_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_rdata;
    logic [31:0] uart_rdata;
    logic        uart_busy;
    logic        uart_rx_valid;
    logic        enable_LEDS, enable_SWITCHES, enable_uart_tx, enable_uart_rx;
    logic [3:0]  strb;
    logic [7:0]  m_led;
    int          passed = 0;
    int          total  = 0;

    periph_bus_ctrl_if bus();

    periph_bus_ctrl #(
        .PERIPH_BASE    (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .enable_LEDS     (enable_LEDS),
        .enable_SWITCHES (enable_SWITCHES),
        .gpio_rdata      (gpio_rdata),
        .enable_uart_tx  (enable_uart_tx),
        .enable_uart_rx  (enable_uart_rx),
        .uart_rdata      (uart_rdata),
        .uart_busy       (uart_busy),
        .uart_rx_valid   (uart_rx_valid)
    );

    always #5 clk = ~clk;

    assign strb = {enable_LEDS, enable_SWITCHES, enable_uart_tx, enable_uart_rx};

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.req    = r;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HWDATA = d;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        uart_busy = 1'b1;
        uart_rx_valid = 1'b0;
        gpio_rdata = 32'h1234_5678;
        uart_rdata = 32'h0;
        drive(1'b1, BASE + 32'h8, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL reset_hready: got %b exp 1", bus.HREADY); else passed++;
        total++; if (bus.HRESP !== 1'b0) $display("FAIL reset_hresp: got %b exp 0", bus.HRESP); else passed++;
        total++; if (bus.HRDATA !== 32'h0) $display("FAIL reset_hrdata: got %h exp 0", bus.HRDATA); else passed++;
        total++; if (strb !== 4'b0000) $display("FAIL reset_strobes: got %b exp 0000", strb); else passed++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        uart_busy = 1'b0;
        reset = 1'b1;
        m_led = 8'h00;
        @(negedge clk);
        drive(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        #2;
        total++; if (bus.HRDATA !== 32'h0) $display("FAIL reset_led_shadow: got %h exp 0", bus.HRDATA); else passed++;
    endtask

    task automatic test_leds;
        @(negedge clk);
        drive(1'b1, 32'h1001_0024, 1'b1, 32'hFFFF_FFA5);
        #2;
        total++; if (strb !== 4'b1000) $display("FAIL leds_wr_strobe: got %b exp 1000", strb); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL leds_wr_ready: got %b exp 1", bus.HREADY); else passed++;
        total++; if (bus.periph_hit !== 1'b1) $display("FAIL leds_wr_hit: got %b exp 1", bus.periph_hit); else passed++;
        m_led = 8'hA5;
        @(negedge clk);
        drive(1'b1, 32'h1001_0024, 1'b0, 32'h0);
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL leds_rd_strobe: got %b exp 0000", strb); else passed++;
        total++; if (bus.HRDATA !== 32'h0000_00A5) $display("FAIL leds_rd_data: got %h exp 000000a5", bus.HRDATA); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL leds_rd_ready: got %b exp 1", bus.HREADY); else passed++;
        @(negedge clk);
        drive(1'b0, 32'h1001_0024, 1'b0, 32'h0);
        #2;
        total++; if (bus.periph_hit !== 1'b0) $display("FAIL idle_hit: got %b exp 0", bus.periph_hit); else passed++;
        total++; if (bus.HRDATA !== 32'h0) $display("FAIL idle_hrdata: got %h exp 0", bus.HRDATA); else passed++;
    endtask

    task automatic test_registered_reads;
        logic [31:0] rv;
        // SWITCHES
        gpio_rdata = 32'h0000_003C;
        @(negedge clk);
        drive(1'b1, 32'h1001_0028, 1'b0, 32'h0);
        #2;
        total++; if (strb !== 4'b0100) $display("FAIL sw_c0_strobe: got %b exp 0100", strb); else passed++;
        total++; if (bus.HREADY !== 1'b0) $display("FAIL sw_c0_ready: got %b exp 0", bus.HREADY); else passed++;
        @(negedge clk);
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL sw_c1_strobe: got %b exp 0000", strb); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL sw_c1_ready: got %b exp 1", bus.HREADY); else passed++;
        total++; if (bus.HRDATA !== 32'h3C) $display("FAIL sw_c1_data: got %h exp 0000003c", bus.HRDATA); else passed++;
        // UART_RX, back to back
        rv = $urandom;
        uart_rdata = rv;
        @(negedge clk);
        drive(1'b1, 32'h1001_0030, 1'b0, 32'h0);
        #2;
        total++; if (strb !== 4'b0001) $display("FAIL rx_c0_strobe: got %b exp 0001", strb); else passed++;
        total++; if (bus.HREADY !== 1'b0) $display("FAIL rx_c0_ready: got %b exp 0", bus.HREADY); else passed++;
        @(negedge clk);
        #2;
        total++; if (bus.HRDATA !== rv) $display("FAIL rx_c1_data: got %h exp %h", bus.HRDATA, rv); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL rx_c1_ready: got %b exp 1", bus.HREADY); else passed++;
        // STATUS, zero wait
        uart_rx_valid = 1'b1;
        uart_busy = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h1001_0034, 1'b0, 32'h0);
        #2;
        total++; if (bus.HRDATA !== 32'h2) $display("FAIL status_data: got %h exp 00000002", bus.HRDATA); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL status_ready: got %b exp 1", bus.HREADY); else passed++;
        uart_rx_valid = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_uart_tx_backpressure;
        @(negedge clk);
        drive(1'b1, 32'h1001_002C, 1'b1, 32'h41);
        uart_busy = 1'b0;
        #2;
        total++; if (strb !== 4'b0010) $display("FAIL tx_free_strobe: got %b exp 0010", strb); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL tx_free_ready: got %b exp 1", bus.HREADY); else passed++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h1001_002C, 1'b1, 32'h42);
            uart_busy = (k < 5);
            #2;
            total++; if (bus.HREADY !== (k == 5)) $display("FAIL tx_bp_ready c%0d: got %b exp %b", k, bus.HREADY, (k == 5)); else passed++;
            total++; if (strb !== ((k == 5) ? 4'b0010 : 4'b0000)) $display("FAIL tx_bp_strobe c%0d: got %b", k, strb); else passed++;
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        uart_busy = 1'b0;
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL tx_bp_after: got %b exp 0000", strb); else passed++;
    endtask

    task automatic test_errors;
        logic [31:0] ea [6];
        logic        ew [6];
        ea = '{32'h1001_0028, 32'h1001_002C, 32'h1001_0022, 32'h1001_0020, 32'h1001_0038, 32'h1001_0034};
        ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        uart_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, ea[i], ew[i], 32'hDEAD_BEEF);
            #2;
            total++; if (bus.HRESP !== 1'b1) $display("FAIL err_resp %h: got %b exp 1", ea[i], bus.HRESP); else passed++;
            total++; if (bus.HREADY !== 1'b1) $display("FAIL err_ready %h: got %b exp 1", ea[i], bus.HREADY); else passed++;
            total++; if (strb !== 4'b0000) $display("FAIL err_strobe %h: got %b exp 0000", ea[i], strb); else passed++;
        end
        // the erroneous write must not have touched the LED shadow
        @(negedge clk);
        drive(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        #2;
        total++; if (bus.HRDATA !== {24'h0, m_led}) $display("FAIL err_led_kept: got %h exp %h", bus.HRDATA, {24'h0, m_led}); else passed++;
    endtask

    task automatic test_timeout;
`ifdef BUS_TIMEOUT_EN
        for (int k = 0; k <= int'(TMO); k++) begin
            @(negedge clk);
            drive(1'b1, 32'h1001_002C, 1'b1, 32'h43);
            uart_busy = 1'b1;
            #2;
            total++; if (bus.HREADY !== (k == int'(TMO))) $display("FAIL tmo_ready c%0d: got %b", k, bus.HREADY); else passed++;
            total++; if (bus.HRESP !== (k == int'(TMO))) $display("FAIL tmo_resp c%0d: got %b", k, bus.HRESP); else passed++;
            total++; if (strb !== 4'b0000) $display("FAIL tmo_strobe c%0d: got %b", k, strb); else passed++;
        end
`else
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h1001_002C, 1'b1, 32'h43);
            uart_busy = (k < 40);
            #2;
            total++; if (bus.HREADY !== (k == 40)) $display("FAIL txwait_ready c%0d: got %b", k, bus.HREADY); else passed++;
            total++; if (strb !== ((k == 40) ? 4'b0010 : 4'b0000)) $display("FAIL txwait_strobe c%0d: got %b", k, strb); else passed++;
        end
`endif
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        uart_busy = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        drive(1'b1, BASE + 32'h4, 1'b1, 32'h5A);
        #2;
        total++; if (strb !== 4'b1000) $display("FAIL rst_pre_led: got %b exp 1000", strb); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, BASE + 32'hC, 1'b1, 32'h44);
            uart_busy = 1'b1;
            #2;
            total++; if (bus.HREADY !== 1'b0) $display("FAIL rst_stall c%0d: got %b exp 0", k, bus.HREADY); else passed++;
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL rst_mid_ready: got %b exp 1", bus.HREADY); else passed++;
        @(negedge clk);
        uart_busy = 1'b0;
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL rst_mid_strobe: got %b exp 0000", strb); else passed++;
        @(negedge clk);
        reset = 1'b1;
        m_led = 8'h00;
        drive(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        #2;
        total++; if (bus.HRDATA !== 32'h0) $display("FAIL rst_led_cleared: got %h exp 0", bus.HRDATA); else passed++;
        @(negedge clk);
        drive(1'b1, 32'h1000_0000, 1'b0, 32'h0);
        #2;
        total++; if (bus.periph_hit !== 1'b0) $display("FAIL out_hit: got %b exp 0", bus.periph_hit); else passed++;
        total++; if (bus.HREADY !== 1'b1) $display("FAIL out_ready: got %b exp 1", bus.HREADY); else passed++;
        total++; if (bus.HRESP !== 1'b0) $display("FAIL out_resp: got %b exp 0", bus.HRESP); else passed++;
        @(negedge clk);
        drive(1'b1, BASE + 32'hC, 1'b1, 32'h45);
        #2;
        total++; if (strb !== 4'b0010) $display("FAIL rst_reissue_strobe: got %b exp 0010", strb); else passed++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_protocol_violation;
        @(negedge clk);
        drive(1'b1, BASE + 32'h8, 1'b0, 32'h0);
        #2;
        total++; if (strb !== 4'b0100) $display("FAIL pv_rd_strobe: got %b exp 0100", strb); else passed++;
        @(negedge clk);
        drive(1'b0, BASE + 32'h8, 1'b0, 32'h0);
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL pv_rd_drop: got %b exp 0000", strb); else passed++;
        @(negedge clk);
        drive(1'b1, BASE + 32'hC, 1'b1, 32'h46);
        uart_busy = 1'b1;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        uart_busy = 1'b0;
        #2;
        total++; if (strb !== 4'b0000) $display("FAIL pv_tx_drop: got %b exp 0000", strb); else passed++;
        @(negedge clk);
        drive(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        #2;
        total++; if (bus.HRDATA !== {24'h0, m_led}) $display("FAIL pv_recover: got %h exp %h", bus.HRDATA, {24'h0, m_led}); else passed++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0]  a, wd, off, exp_rd;
        logic         w, rxv, in_win, tmo, check_rd;
        logic [3:0]   exp_strb;
        int unsigned  nb, stall;
        int           kind; // 0 outside, 1 error, 2 leds, 3 switches, 4 uart_tx, 5 uart_rx, 6 status
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                a = BASE + 32'(4 * $urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            end else begin
                a = $urandom;
                if (a >= BASE && a < BASE + 32'd32) a = a ^ 32'h8000_0000;
            end
            w          = 1'($urandom_range(0, 1));
            wd         = $urandom;
            nb         = $urandom_range(0, 10);
            rxv        = 1'($urandom_range(0, 1));
            gpio_rdata = $urandom;
            uart_rdata = $urandom;
            in_win     = (a >= BASE) && (a < BASE + 32'd32);
            off        = a - BASE;
            kind       = in_win ? 1 : 0;
            if (in_win && (off % 4) == 0) begin
                if (off == 4)               kind = 2;
                else if (off == 8  && !w)   kind = 3;
                else if (off == 12 && w)    kind = 4;
                else if (off == 16 && !w)   kind = 5;
                else if (off == 20 && !w)   kind = 6;
            end
            tmo   = 1'b0;
            stall = 0;
            if (kind == 3 || kind == 5) stall = 1;
            if (kind == 4) begin
`ifdef BUS_TIMEOUT_EN
                if (nb > TMO) begin
                    stall = TMO;
                    tmo   = 1'b1;
                end else begin
                    stall = nb;
                end
`else
                stall = nb;
`endif
            end
            exp_rd = 32'h0;
            case (kind)
                2: exp_rd = {24'h0, m_led};
                3: exp_rd = gpio_rdata;
                5: exp_rd = uart_rdata;
                6: exp_rd = {30'h0, rxv, (nb > 0)};
                default: exp_rd = 32'h0;
            endcase
            check_rd = (kind == 0) || (!w && kind != 1);
            for (int unsigned k = 0; k <= stall; k++) begin
                @(negedge clk);
                drive(1'b1, a, w, wd);
                uart_busy     = (k < nb);
                uart_rx_valid = rxv;
                #2;
                exp_strb = 4'b0000;
                if (kind == 2 && w && k == 0)         exp_strb = 4'b1000;
                if (kind == 3 && k == 0)              exp_strb = 4'b0100;
                if (kind == 5 && k == 0)              exp_strb = 4'b0001;
                if (kind == 4 && k == stall && !tmo)  exp_strb = 4'b0010;
                total++; if (bus.HREADY !== (k == stall)) $display("FAIL rnd_ready #%0d a=%h c%0d: got %b exp %b", i, a, k, bus.HREADY, (k == stall)); else passed++;
                total++; if (strb !== exp_strb) $display("FAIL rnd_strobe #%0d a=%h c%0d: got %b exp %b", i, a, k, strb, exp_strb); else passed++;
                total++; if (bus.periph_hit !== in_win) $display("FAIL rnd_hit #%0d a=%h: got %b exp %b", i, a, bus.periph_hit, in_win); else passed++;
                if (k == stall) begin
                    total++; if (bus.HRESP !== (kind == 1 || tmo)) $display("FAIL rnd_resp #%0d a=%h: got %b exp %b", i, a, bus.HRESP, (kind == 1 || tmo)); else passed++;
                    if (check_rd) begin
                        total++; if (bus.HRDATA !== exp_rd) $display("FAIL rnd_rdata #%0d a=%h: got %h exp %h", i, a, bus.HRDATA, exp_rd); else passed++;
                    end
                end
            end
            if (kind == 2 && w) m_led = wd[7:0];
            @(negedge clk);
            drive(1'b0, a, w, wd);
            uart_busy = 1'b0;
            #2;
            total++; if (bus.HREADY !== 1'b1 || strb !== 4'b0000) $display("FAIL rnd_idle #%0d: ready %b strobes %b exp 1/0000", i, bus.HREADY, strb); else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_leds();
        test_registered_reads();
        test_uart_tx_backpressure();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        test_protocol_violation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
